// File: rtl/usb_hub_pkg.sv
// Shared hub definitions: line-state FSM encodings, raw line codes, and timer width helper.
package usb_hub_pkg;

   localparam logic [2:0] LS_DETACHED  = 3'd0;
   localparam logic [2:0] LS_ATTACH    = 3'd1;
   localparam logic [2:0] LS_IDLE      = 3'd2;
   localparam logic [2:0] LS_BUS_RESET = 3'd3;
   localparam logic [2:0] LS_SUSPEND   = 3'd4;
   localparam logic [2:0] LS_RESUME    = 3'd5;

   localparam logic [1:0] LINE_SE0  = 2'b00;
   localparam logic [1:0] LINE_FS_J = 2'b10;
   localparam logic [1:0] LINE_LS_J = 2'b01;
   localparam logic [1:0] LINE_SE1  = 2'b11;

   typedef enum logic [2:0] {
      ST_DETACHED  = LS_DETACHED,
      ST_ATTACH    = LS_ATTACH,
      ST_IDLE      = LS_IDLE,
      ST_BUS_RESET = LS_BUS_RESET,
      ST_SUSPEND   = LS_SUSPEND,
      ST_RESUME    = LS_RESUME
   } lsm_state_t;

   function automatic int max5(input int a, input int b, input int c, input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/usb_lsm_timer.sv
// Saturating cycle counter; restart loads 1 so the restarting sample itself counts.
// reached is high when the current enabled sample is the threshold-th consecutive one.
module usb_lsm_timer #(
   parameter int W = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic         restart,
   input  logic [W-1:0] threshold,
   output logic         reached
);

   logic [W-1:0] count;
   logic [W-1:0] base;

   assign base    = restart ? '0 : count;
   assign reached = ({1'b0, base} + (W+1)'(1)) >= {1'b0, threshold};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (restart)
            count <= W'(1);
         else if (count != '1)
            count <= count + W'(1);
      end
   end

endmodule

// File: rtl/usb_line_state_monitor.sv
// Per-port USB line-state monitor: attach/speed, bus reset, detach, suspend/resume decode.
// Suspend/resume support is built only when USB_LSM_SUSPEND_EN is defined.
module usb_line_state_monitor
   import usb_hub_pkg::*;
#(
   parameter int ATTACH_CYCLES  = 16,
   parameter int RESET_CYCLES   = 20,
   parameter int DETACH_CYCLES  = 64,
   parameter int SUSPEND_CYCLES = 48,
   parameter int RESUME_CYCLES  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] usb_signals,
   output logic       attached,
   output logic       low_speed,
   output logic [1:0] j_state,
   output logic [1:0] k_state,
   output logic       bus_reset,
   output logic       suspended,
   output logic       resume_pulse,
   output logic       line_error,
   output logic [2:0] state
);

   localparam int CNT_W = $clog2(max5(ATTACH_CYCLES, RESET_CYCLES, DETACH_CYCLES,
                                      SUSPEND_CYCLES, RESUME_CYCLES) + 1);
   localparam logic [CNT_W-1:0] ATT_T = CNT_W'(ATTACH_CYCLES);
   localparam logic [CNT_W-1:0] RST_T = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] DET_T = CNT_W'(DETACH_CYCLES);
`ifdef USB_LSM_SUSPEND_EN
   localparam logic [CNT_W-1:0] SUS_T = CNT_W'(SUSPEND_CYCLES);
   localparam logic [CNT_W-1:0] RES_T = CNT_W'(RESUME_CYCLES);
`endif

   lsm_state_t       state_q, state_d;
   logic [1:0]       last_line, cand_q, cand_d, j_q, k_q;
   logic             low_q, latch, err_q, pulse_d;
   logic             cnt_clr, cnt_en, line_chg, reached;
   logic [CNT_W-1:0] thr;

   // A change of line value means any counting condition starts afresh.
   assign line_chg = (usb_signals != last_line);

   always_comb begin
      thr = ATT_T;
      case (state_q)
         ST_IDLE:      thr = RST_T;
         ST_BUS_RESET: thr = DET_T;
`ifdef USB_LSM_SUSPEND_EN
         ST_SUSPEND:   thr = (usb_signals == LINE_SE0) ? RST_T : RES_T;
`endif
         default:      thr = ATT_T;
      endcase
`ifdef USB_LSM_SUSPEND_EN
      if (state_q == ST_IDLE && usb_signals != LINE_SE0) thr = SUS_T;
`endif
   end

   usb_lsm_timer #(.W(CNT_W)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .clear     (cnt_clr),
      .enable    (cnt_en),
      .restart   (line_chg),
      .threshold (thr),
      .reached   (reached)
   );

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      latch   = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      pulse_d = 1'b0;
      if (usb_signals == LINE_SE1) begin
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            ST_DETACHED: begin
               if (usb_signals != LINE_SE0) begin
                  state_d = ST_ATTACH;
                  cand_d  = usb_signals;
                  cnt_en  = 1'b1;
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            ST_ATTACH: begin
               if (usb_signals == LINE_SE0) begin
                  state_d = ST_DETACHED;
                  cnt_clr = 1'b1;
               end else if (usb_signals == cand_q) begin
                  cnt_en = 1'b1;
                  if (reached) begin
                     state_d = ST_IDLE;
                     latch   = 1'b1;
                     cnt_clr = 1'b1;
                  end
               end else begin
                  cand_d = usb_signals;
                  cnt_en = 1'b1;
               end
            end
            ST_IDLE: begin
               if (usb_signals == LINE_SE0) begin
                  cnt_en = 1'b1;
                  // Counter keeps running into BUS_RESET so detach sees cumulative SE0.
                  if (reached) state_d = ST_BUS_RESET;
`ifdef USB_LSM_SUSPEND_EN
               end else if (usb_signals == j_q) begin
                  cnt_en = 1'b1;
                  if (reached) begin
                     state_d = ST_SUSPEND;
                     cnt_clr = 1'b1;
                  end
`endif
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            ST_BUS_RESET: begin
               if (usb_signals == LINE_SE0) begin
                  cnt_en = 1'b1;
                  if (reached) begin
                     state_d = ST_DETACHED;
                     cnt_clr = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
                  latch   = 1'b1;
                  cnt_clr = 1'b1;
               end
            end
`ifdef USB_LSM_SUSPEND_EN
            ST_SUSPEND: begin
               if (usb_signals == LINE_SE0) begin
                  cnt_en = 1'b1;
                  if (reached) state_d = ST_BUS_RESET;
               end else if (usb_signals == k_q) begin
                  cnt_en = 1'b1;
                  if (reached) begin
                     state_d = ST_RESUME;
                     cnt_clr = 1'b1;
                  end
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            ST_RESUME: begin
               cnt_clr = 1'b1;
               if (usb_signals != k_q) begin
                  state_d = ST_IDLE;
                  pulse_d = 1'b1;
               end
            end
`endif
            default: begin
               state_d = ST_DETACHED;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_DETACHED;
         last_line <= LINE_SE0;
         cand_q    <= LINE_FS_J;
         j_q       <= LINE_FS_J;
         k_q       <= LINE_LS_J;
         low_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_line <= usb_signals;
         cand_q    <= cand_d;
         err_q     <= (usb_signals == LINE_SE1);
         if (latch) begin
            j_q   <= usb_signals;
            k_q   <= ~usb_signals;
            low_q <= (usb_signals == LINE_LS_J);
         end
      end
   end

`ifdef USB_LSM_SUSPEND_EN
   logic pulse_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) pulse_q <= 1'b0;
      else       pulse_q <= pulse_d;
   end
   assign suspended    = (state_q == ST_SUSPEND) || (state_q == ST_RESUME);
   assign resume_pulse = pulse_q;
`else
   assign suspended    = 1'b0;
   assign resume_pulse = 1'b0;
`endif

   assign state      = state_q;
   assign attached   = (state_q != ST_DETACHED) && (state_q != ST_ATTACH);
   assign bus_reset  = (state_q == ST_BUS_RESET);
   assign low_speed  = low_q;
   assign j_state    = j_q;
   assign k_state    = k_q;
   assign line_error = err_q;

endmodule

// File: tb/tb_usb_line_state_monitor.sv
// Directed-vector bench for usb_line_state_monitor with default timer parameters.
module tb_usb_line_state_monitor;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] usb_signals = 2'b00;
   logic       attached, low_speed, bus_reset, suspended, resume_pulse, line_error;
   logic [1:0] j_state, k_state;
   logic [2:0] state;
   int total = 0;
   int bad   = 0;

   usb_line_state_monitor dut (
      .clock        (clock),
      .reset        (reset),
      .usb_signals  (usb_signals),
      .attached     (attached),
      .low_speed    (low_speed),
      .j_state      (j_state),
      .k_state      (k_state),
      .bus_reset    (bus_reset),
      .suspended    (suspended),
      .resume_pulse (resume_pulse),
      .line_error   (line_error),
      .state        (state)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic [1:0] v, input int n);
      repeat (n) begin
         usb_signals = v;
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      usb_signals = 2'b00;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
      total++; if (j_state !== 2'b10 || k_state !== 2'b01) begin bad++; $display("FAIL reset_jk got=%b/%b want=10/01", j_state, k_state); end
      total++; if ({attached, low_speed, bus_reset, suspended, resume_pulse, line_error} !== 6'b0) begin
         bad++; $display("FAIL reset_flags got=%b want=000000", {attached, low_speed, bus_reset, suspended, resume_pulse, line_error}); end
   endtask

   task automatic test_fs_attach();
      do_reset();
      drive(2'b10, 15);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL fs_attach_early got=%0d want=1", state); end
      drive(2'b10, 1);
      total++; if (state !== 3'd2 || attached !== 1'b1) begin bad++; $display("FAIL fs_attach_state got=%0d/%b want=2/1", state, attached); end
      total++; if (low_speed !== 1'b0 || j_state !== 2'b10 || k_state !== 2'b01) begin
         bad++; $display("FAIL fs_attach_polarity got=%b %b %b want=0 10 01", low_speed, j_state, k_state); end
   endtask

   task automatic test_candidate_restart();
      do_reset();
      drive(2'b01, 15);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL cand_ls_pending got=%0d want=1", state); end
      drive(2'b10, 15);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL cand_fs_pending got=%0d want=1", state); end
      drive(2'b10, 1);
      total++; if (state !== 3'd2 || j_state !== 2'b10 || low_speed !== 1'b0) begin
         bad++; $display("FAIL cand_fs_attach got=%0d %b %b want=2 10 0", state, j_state, low_speed); end
   endtask

   task automatic test_bus_reset_detach();
      do_reset();
      drive(2'b10, 16);
      drive(2'b00, 19);
      total++; if (bus_reset !== 1'b0 || state !== 3'd2) begin bad++; $display("FAIL busrst_early got=%b/%0d want=0/2", bus_reset, state); end
      drive(2'b00, 1);
      total++; if (bus_reset !== 1'b1 || state !== 3'd3) begin bad++; $display("FAIL busrst_enter got=%b/%0d want=1/3", bus_reset, state); end
      drive(2'b00, 43);
      total++; if (state !== 3'd3) begin bad++; $display("FAIL detach_early got=%0d want=3", state); end
      drive(2'b00, 1);
      total++; if (state !== 3'd0 || attached !== 1'b0 || bus_reset !== 1'b0) begin
         bad++; $display("FAIL detach got=%0d %b %b want=0 0 0", state, attached, bus_reset); end
   endtask

   task automatic test_reset_exit_ls();
      do_reset();
      drive(2'b10, 16);
      drive(2'b00, 30);
      total++; if (state !== 3'd3) begin bad++; $display("FAIL rstexit_in_reset got=%0d want=3", state); end
      drive(2'b01, 1);
      total++; if (state !== 3'd2 || low_speed !== 1'b1 || bus_reset !== 1'b0) begin
         bad++; $display("FAIL rstexit_state got=%0d %b %b want=2 1 0", state, low_speed, bus_reset); end
      total++; if (j_state !== 2'b01 || k_state !== 2'b10) begin bad++; $display("FAIL rstexit_jk got=%b/%b want=01/10", j_state, k_state); end
   endtask

   task automatic test_suspend();
      do_reset();
      drive(2'b10, 16);
`ifdef USB_LSM_SUSPEND_EN
      drive(2'b10, 47);
      total++; if (suspended !== 1'b0) begin bad++; $display("FAIL susp_early got=%b want=0", suspended); end
      drive(2'b10, 1);
      total++; if (suspended !== 1'b1 || state !== 3'd4) begin bad++; $display("FAIL susp_enter got=%b/%0d want=1/4", suspended, state); end
      drive(2'b01, 3);
      total++; if (state !== 3'd4) begin bad++; $display("FAIL resume_early got=%0d want=4", state); end
      drive(2'b01, 1);
      total++; if (state !== 3'd5 || suspended !== 1'b1) begin bad++; $display("FAIL resume_enter got=%0d/%b want=5/1", state, suspended); end
      drive(2'b10, 1);
      total++; if (resume_pulse !== 1'b1 || state !== 3'd2) begin bad++; $display("FAIL resume_pulse got=%b/%0d want=1/2", resume_pulse, state); end
      drive(2'b10, 1);
      total++; if (resume_pulse !== 1'b0) begin bad++; $display("FAIL resume_pulse_width got=%b want=0", resume_pulse); end
`else
      drive(2'b10, 200);
      total++; if (state !== 3'd2 || suspended !== 1'b0) begin bad++; $display("FAIL no_suspend got=%0d/%b want=2/0", state, suspended); end
      total++; if (resume_pulse !== 1'b0) begin bad++; $display("FAIL no_resume_pulse got=%b want=0", resume_pulse); end
`endif
   endtask

   task automatic test_line_error();
      do_reset();
      drive(2'b10, 10);
      total++; if (state !== 3'd1 || line_error !== 1'b0) begin bad++; $display("FAIL se1_pre got=%0d/%b want=1/0", state, line_error); end
      drive(2'b11, 1);
      total++; if (line_error !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL se1_pulse got=%b/%0d want=1/1", line_error, state); end
      drive(2'b10, 1);
      total++; if (line_error !== 1'b0) begin bad++; $display("FAIL se1_pulse_width got=%b want=0", line_error); end
      drive(2'b10, 14);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL se1_restart got=%0d want=1", state); end
      drive(2'b10, 1);
      total++; if (state !== 3'd2) begin bad++; $display("FAIL se1_attach got=%0d want=2", state); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(2'b01, 16);
      drive(2'b00, 25);
      total++; if (state !== 3'd3 || j_state !== 2'b01) begin bad++; $display("FAIL areset_pre got=%0d/%b want=3/01", state, j_state); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (state !== 3'd0 || bus_reset !== 1'b0 || attached !== 1'b0) begin
         bad++; $display("FAIL areset_state got=%0d %b %b want=0 0 0", state, bus_reset, attached); end
      total++; if (j_state !== 2'b10 || k_state !== 2'b01 || low_speed !== 1'b0) begin
         bad++; $display("FAIL areset_jk got=%b %b %b want=10 01 0", j_state, k_state, low_speed); end
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fs_attach();
      test_candidate_restart();
      test_bus_reset_detach();
      test_reset_exit_ls();
      test_suspend();
      test_line_error();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
